multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle ARM controller: FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared ALU and a unified instruction/data memory.
- Adds an internal NZCV flag register with S-bit/CMP update, full ARM condition-code evaluation, BL link write and an illegal-instruction pulse.
- Sits between the instruction register and the multicycle datapath muxes/enables.

Parameters:
- ALUCTRL_W, 4, width of ALUControl; the opcode constants are defined at this width.
- ENABLE_BL, 1, when 1, FUNCT[4]=1 branches write PC+4 to R14; when 0, BL decodes as plain B.
- STATE_W, 4, FSM state encoding width; must be at least 4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- COND  in  4  Instr[31:28], from the instruction register
- OP  in  2  Instr[27:26]
- FUNCT  in  6  Instr[25:20]
- RD__  in  4  Instr[15:12]
- ALU_Flags  in  4  NZCV from the ALU, current cycle
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC
- AdrSrc  out  1  0 = PC, 1 = ALUResult latch as memory address
- MemWrite  out  1  data write enable
- RegWrite  out  1  register file write enable
- R14_select_address  out  1  force write address to R14 (BL)
- ResultSrc  out  2  00 ALUOut latch, 01 memory data, 10 ALU direct
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 register B/shifted, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  00 DP rot-imm, 01 mem imm12, 10 branch imm24
- RegSrc  out  2  [0] PC as Rn (branch), [1] Rd as Rm (STR)
- ALUControl  out  ALUCTRL_W  ADD 0100, SUB 0110, CMP 0010, AND 0000, ORR 1100, MOV 1101
- Flags  out  4  registered NZCV
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state_dbg  out  STATE_W  current state, for debug

Behaviour:
- Reset (synchronous, active-high): state = FETCH, Flags = 0000. While reset is high, every registered output reads 0. Reset asserted mid-instruction aborts it on the next edge with no write enables asserted in that cycle.
- Outputs are Moore (state-only) except RegWrite, MemWrite and PCWrite in execute-class states, which are gated by cond_met latched in DECODE.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. Next state DECODE.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUControl=ADD to form PC+8.
  - Drives RegSrc per OP and ImmSrc per OP.
  - Evaluates cond_met from Flags for all 15 codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. COND=1111 gives cond_met=0.
  - Next state:
    - cond_met=0: FETCH (squash).
    - OP=01: MEMADR.
    - OP=00 with FUNCT[5]=0: EXECR.
    - OP=00 with FUNCT[5]=1: EXECI.
    - OP=10: BRANCH.
    - OP=11, or an unsupported DP cmd: FETCH with illegal=1.
- EXECR/EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from cmd=FUNCT[4:1].
  - Flags <= ALU_Flags at the end of this state when FUNCT[0]=1 or cmd is CMP.
  - Next state: CMP goes to FETCH, otherwise ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00. Next state FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - FUNCT[0]=1 (LDR): next state MEMRD.
  - FUNCT[0]=0 (STR): next state MEMWR.
- MEMRD: AdrSrc=1. Next state MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - If FUNCT[4]=1 and ENABLE_BL=1: also RegWrite=1 and R14_select_address=1, writing the PC+4 latch.
  - Next state FETCH.
- Latencies in cycles: DP 4, CMP 3, LDR 5, STR 4, B/BL 3, squashed instruction 2.
- A write to R15 (RD__=1111) in ALUWB or MEMWB also asserts PCWrite.
- No write enable is ever asserted outside the states listed above.

Decomposition:
- Package multicycle_pkg holds:
  - state enum: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH.
  - ALUControl constants, COND code constants, ResultSrc/ALUSrcB encodings.
- Sub-module cond_check: combinational. Inputs COND and Flags; outputs cond_met and flag_write qualification.

Test Plan:
- Reset, then ADD r1,r2,r3 (OP=00, FUNCT=001000, COND=1110) -> FETCH→DECODE→EXECR→ALUWB→FETCH; RegWrite=1 only in cycle 4; ALUControl=0100 in EXECR.
- CMP with ALU_Flags=0100, then BEQ (COND=0000, OP=10) -> Flags=0100; BRANCH entered, PCWrite=1 in cycle 3. Repeat with ALU_Flags=0000 -> squash, DECODE→FETCH, no PCWrite beyond FETCH.
- LDR (OP=01, FUNCT=011001) -> 5-cycle sequence; AdrSrc=1 in MEMRD; RegWrite=1 with ResultSrc=01 in MEMWB.
- STR (FUNCT=011000) -> MemWrite=1 only in cycle 4; RegWrite never asserted.
- BL (OP=10, FUNCT=110000) with ENABLE_BL=1 -> BRANCH asserts RegWrite, R14_select_address=1, PCWrite=1. With ENABLE_BL=0 -> RegWrite=0.
- reset=1 during MEMRD of an LDR -> next state FETCH, no RegWrite, Flags=0000. OP=11 -> illegal=1 for exactly one cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU
// control codes, data-processing cmd field, condition codes and the
// datapath mux select encodings.
package multicycle_pkg;

  // FSM state codes (4 bits wide; debug output zero-extends as needed)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXECR  = 4'd2;
  localparam logic [3:0] S_EXECI  = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  // ALUControl codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_CMP = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  // Data-processing cmd field, Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Instruction class, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Maps a DP cmd to {supported, ALUControl}. Unsupported cmds return
  // supported=0 so DECODE can flag them as illegal.
  function automatic logic [4:0] dp_decode(input logic [3:0] cmd);
    logic [4:0] r;
    case (cmd)
      CMD_ADD: r = {1'b1, ALU_ADD};
      CMD_SUB: r = {1'b1, ALU_SUB};
      CMD_CMP: r = {1'b1, ALU_CMP};
      CMD_AND: r = {1'b1, ALU_AND};
      CMD_ORR: r = {1'b1, ALU_ORR};
      CMD_MOV: r = {1'b1, ALU_MOV};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Purpose: ARM condition-code evaluation against the registered NZCV flags.
// Latency: combinational. Backpressure: none.
// Ports: cond/flags in; cond_met (instruction executes), flag_write
//        (flag update requested and permitted by the condition) out.
module cond_check
  import multicycle_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  input  logic       set_flags_req,
  output logic       cond_met,
  output logic       flag_write
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      COND_EQ: cond_met = z;
      COND_NE: cond_met = ~z;
      COND_CS: cond_met = c;
      COND_CC: cond_met = ~c;
      COND_MI: cond_met = n;
      COND_PL: cond_met = ~n;
      COND_VS: cond_met = v;
      COND_VC: cond_met = ~v;
      COND_HI: cond_met = c & ~z;
      COND_LS: cond_met = ~c | z;
      COND_GE: cond_met = (n == v);
      COND_LT: cond_met = (n != v);
      COND_GT: cond_met = ~z & (n == v);
      COND_LE: cond_met = z | (n != v);
      COND_AL: cond_met = 1'b1;
      COND_NV: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  end

  assign flag_write = cond_met & set_flags_req;

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle ARM controller FSM with NZCV flag register, BL and illegal decode.
// Latency: DP 4, CMP 3, LDR 5, STR 4, B/BL 3, squashed 2 cycles per instruction.
// Backpressure: none; one state per clock, no stalls.
// Ports: Instr fields (COND/OP/FUNCT/RD__) and ALU_Flags in; datapath
//        enables/mux selects, ALUControl, registered Flags, illegal pulse,
//        state_dbg out.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int ENABLE_BL = 1,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           COND,
  input  logic [1:0]           OP,
  input  logic [5:0]           FUNCT,
  input  logic [3:0]           RD__,
  input  logic [3:0]           ALU_Flags,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 R14_select_address,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state_dbg
);

  localparam logic BL_ON = (ENABLE_BL != 0);

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_met_q, cond_met_d;

  logic [3:0] cmd;
  logic       dp_legal, is_cmp, bl_en, rd_pc;
  logic [3:0] dp_ctl;
  logic       cond_met, flag_write;

  logic       ir_wr, pc_wr, adr, mem_wr, reg_wr, r14, ill;
  logic [1:0] res_src, src_b, imm_src, reg_src;
  logic       src_a;
  logic [3:0] alu_ctl;

  assign cmd                = FUNCT[4:1];
  assign {dp_legal, dp_ctl} = dp_decode(cmd);
  assign is_cmp             = (cmd == CMD_CMP);
  assign bl_en              = BL_ON & FUNCT[4];
  assign rd_pc              = (RD__ == 4'hF);

  // Flags are stable from DECODE through EXEC (they only change at the
  // end of EXEC), so the same evaluation serves both states.
  cond_check u_cond_check (
    .cond          (COND),
    .flags         (flags_q),
    .set_flags_req (FUNCT[0] | is_cmp),
    .cond_met      (cond_met),
    .flag_write    (flag_write)
  );

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    cond_met_d = cond_met_q;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    adr        = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    r14        = 1'b0;
    ill        = 1'b0;
    res_src    = RES_ALUOUT;
    src_a      = 1'b0;
    src_b      = SRCB_REG;
    alu_ctl    = ALU_ADD;
    // Immediate/register selects follow the instruction class for every
    // post-fetch state: EXECI, MEMADR and BRANCH consume ExtImm, and the
    // register read ports must keep pointing at the same operands.
    imm_src    = IMM_DP;
    reg_src    = 2'b00;
    if (state_q != S_FETCH) begin
      imm_src = (OP == OP_MEM) ? IMM_MEM : ((OP == OP_BR) ? IMM_BR : IMM_DP);
      reg_src = {OP == OP_MEM, OP == OP_BR};
    end

    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALU;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a      = 1'b1;
        src_b      = SRCB_FOUR;
        cond_met_d = cond_met;
        state_d    = S_FETCH;
        if (cond_met) begin
          case (OP)
            OP_MEM: state_d = S_MEMADR;
            OP_BR:  state_d = S_BRANCH;
            OP_DP: begin
              if (dp_legal) state_d = FUNCT[5] ? S_EXECI : S_EXECR;
              else          ill     = 1'b1;
            end
            default: ill = 1'b1;
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_ctl = dp_ctl;
        if (cond_met_q && flag_write) flags_d = ALU_Flags;
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = cond_met_q;
        pc_wr   = cond_met_q & rd_pc;
        res_src = RES_ALUOUT;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        src_b   = SRCB_IMM;
        state_d = FUNCT[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr     = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr  = cond_met_q;
        pc_wr   = cond_met_q & rd_pc;
        res_src = RES_MEM;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        adr     = 1'b1;
        mem_wr  = cond_met_q;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        res_src = RES_ALU;
        pc_wr   = cond_met_q;
        reg_wr  = cond_met_q & bl_en;
        r14     = bl_en;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      flags_q    <= 4'b0000;
      cond_met_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      cond_met_q <= cond_met_d;
    end
  end

  // Reset masks every enable in the cycle it is asserted, so an aborted
  // instruction cannot commit anything, and the registered outputs read 0.
  assign IRWrite            = ir_wr  & ~reset;
  assign PCWrite            = pc_wr  & ~reset;
  assign MemWrite           = mem_wr & ~reset;
  assign RegWrite           = reg_wr & ~reset;
  assign illegal            = ill    & ~reset;
  assign AdrSrc             = adr;
  assign R14_select_address = r14;
  assign ResultSrc          = res_src;
  assign ALUSrcA            = src_a;
  assign ALUSrcB            = src_b;
  assign ImmSrc             = imm_src;
  assign RegSrc             = reg_src;
  assign ALUControl         = ALUCTRL_W'(alu_ctl);
  assign Flags              = reset ? 4'b0000 : flags_q;
  assign state_dbg          = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;

  logic       ir_write, pc_write, adr_src, mem_write, reg_write, r14_sel, alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic [3:0] alu_ctl, flags, state_dbg;

  logic       nb_ir_write, nb_pc_write, nb_adr_src, nb_mem_write, nb_reg_write, nb_r14_sel, nb_alu_src_a, nb_illegal;
  logic [1:0] nb_result_src, nb_alu_src_b, nb_imm_src, nb_reg_src;
  logic [3:0] nb_alu_ctl, nb_flags, nb_state_dbg;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .COND(cond), .OP(op), .FUNCT(funct), .RD__(rd), .ALU_Flags(alu_flags),
    .IRWrite(ir_write), .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .RegWrite(reg_write),
    .R14_select_address(r14_sel), .ResultSrc(result_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .ImmSrc(imm_src), .RegSrc(reg_src), .ALUControl(alu_ctl), .Flags(flags), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  multicycle_controller #(.ENABLE_BL(0)) dut_nb (
    .clk(clk), .reset(reset), .COND(cond), .OP(op), .FUNCT(funct), .RD__(rd), .ALU_Flags(alu_flags),
    .IRWrite(nb_ir_write), .PCWrite(nb_pc_write), .AdrSrc(nb_adr_src), .MemWrite(nb_mem_write),
    .RegWrite(nb_reg_write), .R14_select_address(nb_r14_sel), .ResultSrc(nb_result_src),
    .ALUSrcA(nb_alu_src_a), .ALUSrcB(nb_alu_src_b), .ImmSrc(nb_imm_src), .RegSrc(nb_reg_src),
    .ALUControl(nb_alu_ctl), .Flags(nb_flags), .illegal(nb_illegal), .state_dbg(nb_state_dbg)
  );

  // Full observable output word of the main DUT
  logic [27:0] obs_v;
  assign obs_v = {ir_write, pc_write, adr_src, mem_write, reg_write, r14_sel, result_src, alu_src_a,
                  alu_src_b, imm_src, reg_src, alu_ctl, flags, illegal, state_dbg};

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  flags_m;
  logic [27:0] exp_q[$];

  // Condition codes come in complementary pairs: evaluate the even member,
  // invert for odd codes. AL/NV fall out as 1/0.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [4:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {1'b1, 4'b0100};
      4'b0010: return {1'b1, 4'b0110};
      4'b1010: return {1'b1, 4'b0010};
      4'b0000: return {1'b1, 4'b0000};
      4'b1100: return {1'b1, 4'b1100};
      4'b1101: return {1'b1, 4'b1101};
      default: return {1'b0, 4'b0100};
    endcase
  endfunction

  function automatic logic [27:0] pk(input logic irw, pcw, adr, mw, rw, r14, input logic [1:0] rs,
                                     input logic sa, input logic [1:0] sb, imm, rsrc,
                                     input logic [3:0] alu, fl, input logic il, input logic [3:0] st);
    return {irw, pcw, adr, mw, rw, r14, rs, sa, sb, imm, rsrc, alu, fl, il, st};
  endfunction

  // Expected per-cycle output words for one instruction, FETCH first.
  task automatic build(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af);
    logic met, ill, wb_pc, bl, is_cmp;
    logic [1:0] imm, rsrc;
    logic [4:0] dp;
    exp_q.delete();
    met    = cond_ok(c, flags_m);
    dp     = alu_of(f[4:1]);
    is_cmp = (f[4:1] == 4'b1010);
    imm    = (o == 2'b01) ? 2'b01 : ((o == 2'b10) ? 2'b10 : 2'b00);
    rsrc   = {o == 2'b01, o == 2'b10};
    ill    = met && (o == 2'b11 || (o == 2'b00 && !dp[4]));
    wb_pc  = (r == 4'hF);
    bl     = f[4];
    exp_q.push_back(pk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,4'b0100,flags_m,1'b0,4'd0));
    exp_q.push_back(pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,imm,rsrc,4'b0100,flags_m,ill,4'd1));
    if (met && !ill) begin
      case (o)
        2'b00: begin
          exp_q.push_back(pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,f[5] ? 2'b01 : 2'b00,imm,rsrc,
                             dp[3:0],flags_m,1'b0,f[5] ? 4'd3 : 4'd2));
          if (f[0] || is_cmp) flags_m = af;
          if (!is_cmp)
            exp_q.push_back(pk(1'b0,wb_pc,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,imm,rsrc,4'b0100,flags_m,1'b0,4'd4));
        end
        2'b01: begin
          exp_q.push_back(pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,imm,rsrc,4'b0100,flags_m,1'b0,4'd5));
          if (f[0]) begin
            exp_q.push_back(pk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,imm,rsrc,4'b0100,flags_m,1'b0,4'd6));
            exp_q.push_back(pk(1'b0,wb_pc,1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,2'b00,imm,rsrc,4'b0100,flags_m,1'b0,4'd7));
          end else begin
            exp_q.push_back(pk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,imm,rsrc,4'b0100,flags_m,1'b0,4'd8));
          end
        end
        default:
          exp_q.push_back(pk(1'b0,1'b1,1'b0,1'b0,bl,bl,2'b10,1'b1,2'b01,imm,rsrc,4'b0100,flags_m,1'b0,4'd9));
      endcase
    end
  endtask

  // Entry/exit: just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input int idx, input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    build(c, o, f, r, af);
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("rand%0d cyc%0d", idx, i), {4'b0, obs_v}, {4'b0, exp_q[i]});
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] af;
    logic [3:0] lat;
    logic [7:0] rw;
    logic [7:0] mw;
    logic [7:0] pcw;
    logic [7:0] ill;
    logic [3:0] fl;
  } vec_t;

  vec_t vt[18];

  task automatic run_vec(input int i);
    logic [7:0] rwm, mwm, pcm, ilm;
    int cyc;
    rwm = '0; mwm = '0; pcm = '0; ilm = '0; cyc = 0;
    cond = vt[i].cond; op = vt[i].op; funct = vt[i].funct; rd = vt[i].rd; alu_flags = vt[i].af;
    do begin
      @(negedge clk);
      rwm[cyc] = reg_write; mwm[cyc] = mem_write; pcm[cyc] = pc_write; ilm[cyc] = illegal;
      @(posedge clk); #1;
      cyc++;
    end while (state_dbg != 4'd0 && cyc < 8);
    check($sformatf("vec%0d latency", i), 32'(cyc), 32'(vt[i].lat));
    check($sformatf("vec%0d RegWrite cycles", i), 32'(rwm), 32'(vt[i].rw));
    check($sformatf("vec%0d MemWrite cycles", i), 32'(mwm), 32'(vt[i].mw));
    check($sformatf("vec%0d PCWrite cycles", i), 32'(pcm), 32'(vt[i].pcw));
    check($sformatf("vec%0d illegal cycles", i), 32'(ilm), 32'(vt[i].ill));
    check($sformatf("vec%0d Flags", i), 32'(flags), 32'(vt[i].fl));
  endtask

  logic [3:0] legal_cmds[6];

  initial begin
    logic [3:0] rc, rr, raf;
    logic [1:0] ro;
    logic [5:0] rf;

    //          cond   op     funct      rd     af     lat   rw     mw     pcw    ill    fl
    vt[0]  = '{4'hE, 2'b00, 6'b001000, 4'h1, 4'hF, 4'd4, 8'h08, 8'h00, 8'h01, 8'h00, 4'h0}; // ADD
    vt[1]  = '{4'hE, 2'b00, 6'b010101, 4'h0, 4'h4, 4'd3, 8'h00, 8'h00, 8'h01, 8'h00, 4'h4}; // CMP Z
    vt[2]  = '{4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 4'd3, 8'h00, 8'h00, 8'h05, 8'h00, 4'h4}; // BEQ taken
    vt[3]  = '{4'hE, 2'b00, 6'b010101, 4'h0, 4'h0, 4'd3, 8'h00, 8'h00, 8'h01, 8'h00, 4'h0}; // CMP clr
    vt[4]  = '{4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 4'd2, 8'h00, 8'h00, 8'h01, 8'h00, 4'h0}; // BEQ squash
    vt[5]  = '{4'hE, 2'b01, 6'b011001, 4'h2, 4'h0, 4'd5, 8'h10, 8'h00, 8'h01, 8'h00, 4'h0}; // LDR
    vt[6]  = '{4'hE, 2'b01, 6'b011000, 4'h2, 4'h0, 4'd4, 8'h00, 8'h08, 8'h01, 8'h00, 4'h0}; // STR
    vt[7]  = '{4'hE, 2'b10, 6'b110000, 4'h0, 4'h0, 4'd3, 8'h04, 8'h00, 8'h05, 8'h00, 4'h0}; // BL
    vt[8]  = '{4'hE, 2'b00, 6'b001001, 4'hF, 4'h9, 4'd4, 8'h08, 8'h00, 8'h09, 8'h00, 4'h9}; // ADDS pc
    vt[9]  = '{4'h1, 2'b00, 6'b100100, 4'h3, 4'h6, 4'd4, 8'h08, 8'h00, 8'h01, 8'h00, 4'h9}; // SUBNE imm
    vt[10] = '{4'h4, 2'b00, 6'b011010, 4'h4, 4'h0, 4'd4, 8'h08, 8'h00, 8'h01, 8'h00, 4'h9}; // MOVMI
    vt[11] = '{4'hF, 2'b00, 6'b001000, 4'h1, 4'h0, 4'd2, 8'h00, 8'h00, 8'h01, 8'h00, 4'h9}; // NV
    vt[12] = '{4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 4'd2, 8'h00, 8'h00, 8'h01, 8'h02, 4'h9}; // OP=11
    vt[13] = '{4'hE, 2'b00, 6'b000010, 4'h1, 4'h0, 4'd2, 8'h00, 8'h00, 8'h01, 8'h02, 4'h9}; // EOR
    vt[14] = '{4'hE, 2'b01, 6'b011001, 4'hF, 4'h0, 4'd5, 8'h10, 8'h00, 8'h11, 8'h00, 4'h9}; // LDR pc
    vt[15] = '{4'hA, 2'b00, 6'b011001, 4'h5, 4'h2, 4'd4, 8'h08, 8'h00, 8'h01, 8'h00, 4'h2}; // ORRSGE
    vt[16] = '{4'hC, 2'b10, 6'b000000, 4'h0, 4'h0, 4'd3, 8'h00, 8'h00, 8'h05, 8'h00, 4'h2}; // BGT
    vt[17] = '{4'hB, 2'b00, 6'b010101, 4'h0, 4'hF, 4'd2, 8'h00, 8'h00, 8'h01, 8'h00, 4'h2}; // CMPLT sq
    legal_cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};

    reset = 1'b1; cond = 4'h0; op = 2'b00; funct = 6'h00; rd = 4'h0; alu_flags = 4'h0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset outputs", {4'b0, obs_v},
          {4'b0, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,4'b0100,4'h0,1'b0,4'd0)});
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i);

    // BL with and without link support
    cond = 4'hE; op = 2'b10; funct = 6'b110000; rd = 4'h0; alu_flags = 4'h0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("BL state", 32'(state_dbg), 32'd9);
    check("BL RegWrite", 32'(reg_write), 32'd1);
    check("BL R14 select", 32'(r14_sel), 32'd1);
    check("BL PCWrite", 32'(pc_write), 32'd1);
    check("BL nolink RegWrite", 32'(nb_reg_write), 32'd0);
    check("BL nolink R14 select", 32'(nb_r14_sel), 32'd0);
    check("BL nolink PCWrite", 32'(nb_pc_write), 32'd1);
    @(posedge clk); #1;

    // Reset during MEMRD of an LDR (Flags are 0010 from the table)
    cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'h2; alu_flags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); @(posedge clk); #1;
    end
    check("pre-reset state MEMRD", 32'(state_dbg), 32'd6);
    check("pre-reset Flags", 32'(flags), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    check("reset-in-MEMRD enables", {27'b0, ir_write, pc_write, mem_write, reg_write, illegal}, 32'd0);
    check("reset-in-MEMRD Flags", 32'(flags), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post-reset state", 32'(state_dbg), 32'd0);
    check("post-reset Flags", 32'(flags), 32'h0);
    flags_m = 4'h0;

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 400; n++) begin
      rc = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
      if ($urandom_range(0, 9) == 0) ro = 2'b11;
      else ro = 2'($urandom_range(0, 2));
      rf = 6'($urandom_range(0, 63));
      if (ro == 2'b00 && $urandom_range(0, 4) != 0) rf[4:1] = legal_cmds[$urandom_range(0, 5)];
      rr  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      run_instr(n, rc, ro, rf, rr, raf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
